// File: rtl/display_source_sched_if.sv
// Bus between the display sources and display_source_sched: request levels and
// packed source words in, the selected word plus grant/owner/busy status out.
interface display_source_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] word_in;
    logic [15:0]        dataword;
    logic [NREQ-1:0]    grant;
    logic [1:0]         owner;
    logic               busy;

    modport master (output req, word_in, input dataword, grant, owner, busy);
    modport slave  (input req, word_in, output dataword, grant, owner, busy);
endinterface

// File: rtl/display_source_sched.sv
// Round-robin time-sharing of the four-digit hex display between NREQ sources,
// with a minimum dwell per grant. Optional macro SRC_TAG_EN puts the owner index in the top digit.
//
// state  | meaning
// IDLE   | no owner, grant=0, dataword holds last word
// SHOW   | owner's word tracked every cycle, dwell counter running/saturated
// ROTATE | one cycle: pointer moves past owner, next owner picked, dataword held
module display_source_sched #(
    parameter int NREQ  = 4,
    parameter int DWELL = 100000000,
    parameter int CNT_W = 27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    display_source_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHOW, ROTATE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [1:0]       OWNER_MAX = 2'(NREQ - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ptr_q;
    logic [1:0]       owner_q;
    logic [NREQ-1:0]  grant_q;
    logic [15:0]      dataword_q;
    logic             busy_q;

    logic [1:0]       base;
    logic [2:0]       sum;
    logic [1:0]       pick_idx;
    logic             pick_found;
    logic [NREQ-1:0]  pick_onehot;
    logic [15:0]      owner_word;
    logic [15:0]      show_word;
    logic             dwell_done;
    logic             others_req;
    logic             owner_req;

    // Search upward from base with wrap; descending loop so the nearest index wins.
    // In ROTATE base is owner+1, which leaves the owner as the last candidate.
    always_comb begin
        base = ptr_q;
        if (state_q == ROTATE)
            base = (owner_q == OWNER_MAX) ? 2'd0 : owner_q + 2'd1;
        sum        = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, base} + 3'(k);
            if (sum >= 3'(NREQ))
                sum = sum - 3'(NREQ);
            if (bus.req[sum[1:0]]) begin
                pick_idx   = sum[1:0];
                pick_found = 1'b1;
            end
        end
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        owner_word = bus.word_in[15:0];
        for (int i = 1; i < NREQ; i++)
            if (owner_q == 2'(i))
                owner_word = bus.word_in[16*i +: 16];
    end

`ifdef SRC_TAG_EN
    assign show_word = {2'b00, owner_q, owner_word[11:0]};
`else
    assign show_word = owner_word;
`endif

    assign dwell_done = (cnt_q == CNT_LAST);
    assign others_req = |(bus.req & ~grant_q);
    assign owner_req  = |(bus.req & grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            dataword_q <= 16'h0000;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    if (pick_found) begin
                        state_q <= SHOW;
                        grant_q <= pick_onehot;
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHOW: begin
                    dataword_q <= show_word;
                    if (!dwell_done) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (others_req) begin
                        state_q <= ROTATE;
                        busy_q  <= 1'b0;
                    end else if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                ROTATE: begin
                    ptr_q <= base;
                    if (pick_found) begin
                        state_q <= SHOW;
                        grant_q <= pick_onehot;
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        // Requester vanished during the rotate cycle.
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dataword = dataword_q;
    assign bus.grant    = grant_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_display_source_sched.sv
// Directed bench for display_source_sched with DWELL=8, NREQ=4: a vector table
// for a single-source grant plus hand sequences for rotation, dwell, hold and reset.
module tb_display_source_sched;
    localparam int NREQ  = 4;
    localparam int DWELL = 8;
    localparam int CNT_W = 4;
`ifdef SRC_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] w [4];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    display_source_sched_if #(.NREQ(NREQ)) bus ();

    display_source_sched #(.NREQ(NREQ), .DWELL(DWELL), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.word_in = {w[3], w[2], w[1], w[0]};

    typedef struct {
        logic [3:0]  req;
        logic [15:0] w2;
        logic [3:0]  g;
        logic [1:0]  o;
        logic        b;
        logic [15:0] dw;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [15:0] t(input logic [15:0] wd, input logic [1:0] o);
        return TAG ? {2'b00, o, wd[11:0]} : wd;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] g, input logic [1:0] o,
                           input logic b, input logic [15:0] dw);
        chk({nm, "_grant"}, 32'(bus.grant), 32'(g));
        chk({nm, "_owner"}, 32'(bus.owner), 32'(o));
        chk({nm, "_busy"}, 32'(bus.busy), 32'(b));
        chk({nm, "_dw"}, 32'(bus.dataword), 32'(dw));
    endtask

    initial begin
        logic [15:0] prev;
        int g;

        bus.req = '0;
        w[0] = 16'h0000; w[1] = 16'h0000; w[2] = 16'h0000; w[3] = 16'h0000;

        // Single source 2: grant latency, live tracking, hold past dwell, release.
        tbl[0]  = '{4'b0100, 16'h1234, 4'b0100, 2'd2, 1'b1, 16'h0000};
        tbl[1]  = '{4'b0100, 16'h1234, 4'b0100, 2'd2, 1'b1, t(16'h1234, 2'd2)};
        tbl[2]  = '{4'b0100, 16'h1234, 4'b0100, 2'd2, 1'b1, t(16'h1234, 2'd2)};
        for (int i = 3; i <= 10; i++)
            tbl[i] = '{4'b0100, 16'h5678, 4'b0100, 2'd2, 1'b1, t(16'h5678, 2'd2)};
        tbl[11] = '{4'b0000, 16'h5678, 4'b0000, 2'd2, 1'b0, t(16'h5678, 2'd2)};
        tbl[12] = '{4'b0000, 16'h5678, 4'b0000, 2'd2, 1'b0, t(16'h5678, 2'd2)};

        #2;
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
        step();
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("idle%0d_dw", c), 32'(bus.dataword), 32'h0);
            chk($sformatf("idle%0d_grant", c), 32'(bus.grant), 32'h0);
            chk($sformatf("idle%0d_busy", c), 32'(bus.busy), 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            bus.req = tbl[i].req;
            w[2]    = tbl[i].w2;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].o, tbl[i].b, tbl[i].dw);
        end

        // All four requesting from IDLE: 0,1,2,3,0, each 8 SHOW + 1 ROTATE.
        do_reset();
        w[0] = 16'hA0A0; w[1] = 16'hB1B1; w[2] = 16'hC2C2; w[3] = 16'hD3D3;
        bus.req = 4'b1111;
        prev = 16'h0000;
        for (int j = 0; j < 5; j++) begin
            g = j % 4;
            step();
            chk_out($sformatf("rr%0d_start", j), 4'(1 << g), 2'(g), 1'b1, prev);
            if (j < 4) begin
                for (int c = 1; c <= DWELL; c++) begin
                    step();
                    chk($sformatf("rr%0d_c%0d_grant", j, c), 32'(bus.grant), 32'(1 << g));
                    chk($sformatf("rr%0d_c%0d_dw", j, c), 32'(bus.dataword),
                        32'(t(w[g], 2'(g))));
                    chk($sformatf("rr%0d_c%0d_busy", j, c), 32'(bus.busy),
                        32'(c < DWELL));
                end
                prev = t(w[g], 2'(g));
            end
        end

        // Owner 1 drops req mid-dwell while req3 is pending.
        do_reset();
        w[1] = 16'h1B1B; w[3] = 16'hABCD;
        bus.req = 4'b1010;
        step();
        chk_out("drop_start", 4'b0010, 2'd1, 1'b1, 16'h0000);
        for (int c = 1; c <= DWELL; c++) begin
            if (c == 4) bus.req = 4'b1000;
            step();
            chk($sformatf("drop_c%0d_grant", c), 32'(bus.grant), 32'b0010);
        end
        chk("drop_rotate_busy", 32'(bus.busy), 32'h0);
        chk("drop_rotate_dw", 32'(bus.dataword), 32'(t(16'h1B1B, 2'd1)));
        step();
        chk_out("drop_next", 4'b1000, 2'd3, 1'b1, t(16'h1B1B, 2'd1));
        step();
        chk("tag_owner3_dw", 32'(bus.dataword), 32'(t(16'hABCD, 2'd3)));

        // Lone owner held well past the dwell, then released.
        for (int c = 0; c < 50; c++) begin
            step();
            chk($sformatf("hold%0d_grant", c), 32'(bus.grant), 32'b1000);
            chk($sformatf("hold%0d_busy", c), 32'(bus.busy), 32'h1);
        end
        bus.req = 4'b0000;
        step();
        chk_out("release", 4'b0000, 2'd3, 1'b0, t(16'hABCD, 2'd3));
        step();
        chk_out("release_idle", 4'b0000, 2'd3, 1'b0, t(16'hABCD, 2'd3));

        // Pointer was left at 2, so simultaneous requests start at source 2.
        bus.req = 4'b1111;
        step();
        chk_out("ptr_pick", 4'b0100, 2'd2, 1'b1, t(16'hABCD, 2'd3));
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk_out("post_rst", 4'b0001, 2'd0, 1'b1, 16'h0000);
        step();
        chk("post_rst_dw", 32'(bus.dataword), 32'(t(16'hA0A0, 2'd0)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
